// File: rtl/issue_scoreboard.sv
// Register/memory-unit issue scoreboard with RUN/HOLD/DRAIN stall FSM.
// Optional build macro ISSUE_BYPASS_EN: hazard checks see the same-cycle writeback clear.
module issue_scoreboard #(
    parameter int unsigned MEM_LAT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_is_valid,
    input  logic [4:0]  id_is_addra,
    input  logic [4:0]  id_is_addrb,
    input  logic [1:0]  id_is_numop,
    input  logic [4:0]  id_is_regdest,
    input  logic        id_is_writereg,
    input  logic        id_is_readmem,
    input  logic        id_is_writemem,
    input  logic        id_is_sync,
    input  logic [4:0]  wb_is_regdest,
    input  logic        wb_is_writereg,
    output logic        is_if_stall,
    output logic        is_ex_issue,
    output logic [31:0] is_pending,
    output logic [1:0]  is_state,
    output logic [15:0] is_stallcnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HOLD  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    localparam logic [3:0] MEM_LAT_C = 4'(MEM_LAT);

    state_t      state_r, state_nx_s;
    logic [31:0] pend_r, pend_nx_s, pend_view_s, wb_clr_s, id_set_s;
    logic [3:0]  memcnt_r, memcnt_nx_s;
    logic [15:0] stallcnt_r, stallcnt_nx_s;
    logic        raw_s, waw_s, struct_s, sync_s, hazard_s, sync_only_s;
    logic        stall_s, issue_s, mem_op_s;

    // One-hot register mask; register 0 is never tracked.
    function automatic logic [31:0] reg_mask(input logic [4:0] idx, input logic en);
        logic [31:0] m;
        m = 32'd0;
        if (en && (idx != 5'd0)) begin
            m = 32'd1 << idx;
        end else begin
            m = 32'd0;
        end
        return m;
    endfunction

    // Hazard detection and issue decision.
    always_comb begin
        wb_clr_s = reg_mask(wb_is_regdest, wb_is_writereg);
`ifdef ISSUE_BYPASS_EN
        pend_view_s = pend_r & ~wb_clr_s;
`else
        pend_view_s = pend_r;
`endif
        mem_op_s    = id_is_readmem | id_is_writemem;
        raw_s       = ((id_is_numop != 2'd0) && (id_is_addra != 5'd0) && pend_view_s[id_is_addra]) ||
                      (id_is_numop[1] && (id_is_addrb != 5'd0) && pend_view_s[id_is_addrb]);
        waw_s       = id_is_writereg && (id_is_regdest != 5'd0) && pend_view_s[id_is_regdest];
        struct_s    = mem_op_s && (memcnt_r != 4'd0);
        sync_s      = id_is_sync && ((pend_view_s != 32'd0) || (memcnt_r != 4'd0));
        hazard_s    = raw_s | waw_s | struct_s | sync_s;
        sync_only_s = sync_s & ~raw_s & ~waw_s & ~struct_s;
        stall_s     = reset & id_is_valid & hazard_s;
        issue_s     = id_is_valid & ~stall_s;
        id_set_s    = reg_mask(id_is_regdest, issue_s & id_is_writereg);
    end

    // Next values for scoreboard, memory busy counter and stall counter.
    always_comb begin
        pend_nx_s = ((pend_r & ~wb_clr_s) | id_set_s) & 32'hFFFF_FFFE;
        if (issue_s && mem_op_s) begin
            memcnt_nx_s = MEM_LAT_C;
        end else if (memcnt_r != 4'd0) begin
            memcnt_nx_s = memcnt_r - 4'd1;
        end else begin
            memcnt_nx_s = 4'd0;
        end
        if (stall_s && (stallcnt_r != 16'hFFFF)) begin
            stallcnt_nx_s = stallcnt_r + 16'd1;
        end else begin
            stallcnt_nx_s = stallcnt_r;
        end
    end

    // Stall FSM next state; dropping id_is_valid abandons HOLD/DRAIN.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (stall_s && sync_s) begin
                    state_nx_s = ST_DRAIN;
                end else if (stall_s) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (!id_is_valid || !stall_s) begin
                    state_nx_s = ST_RUN;
                end else if (sync_only_s) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (!id_is_valid || ((pend_view_s == 32'd0) && (memcnt_r == 4'd0))) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // State registers; reset discards all outstanding tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_RUN;
            pend_r     <= 32'd0;
            memcnt_r   <= 4'd0;
            stallcnt_r <= 16'd0;
        end else begin
            state_r    <= state_nx_s;
            pend_r     <= pend_nx_s;
            memcnt_r   <= memcnt_nx_s;
            stallcnt_r <= stallcnt_nx_s;
        end
    end

    assign is_if_stall = stall_s;
    assign is_ex_issue = issue_s;
    assign is_pending  = pend_r;
    assign is_state    = state_r;
    assign is_stallcnt = stallcnt_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios then randomized traffic
// against a behavioural model. Honours ISSUE_BYPASS_EN if defined.
module tb_issue_scoreboard;

    localparam int LAT   = 3;
    localparam int RUN   = 0;
    localparam int HOLD  = 1;
    localparam int DRAIN = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_is_valid, id_is_writereg, id_is_readmem, id_is_writemem, id_is_sync;
    logic [4:0]  id_is_addra, id_is_addrb, id_is_regdest, wb_is_regdest;
    logic [1:0]  id_is_numop;
    logic        wb_is_writereg;
    logic        is_if_stall, is_ex_issue;
    logic [31:0] is_pending;
    logic [1:0]  is_state;
    logic [15:0] is_stallcnt;

    issue_scoreboard #(.MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .id_is_valid(id_is_valid), .id_is_addra(id_is_addra), .id_is_addrb(id_is_addrb),
        .id_is_numop(id_is_numop), .id_is_regdest(id_is_regdest), .id_is_writereg(id_is_writereg),
        .id_is_readmem(id_is_readmem), .id_is_writemem(id_is_writemem), .id_is_sync(id_is_sync),
        .wb_is_regdest(wb_is_regdest), .wb_is_writereg(wb_is_writereg),
        .is_if_stall(is_if_stall), .is_ex_issue(is_ex_issue), .is_pending(is_pending),
        .is_state(is_state), .is_stallcnt(is_stallcnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit [31:0] pend_m;
    int        memcnt_m, stallcnt_m, state_m;
    bit        m_raw, m_waw, m_str, m_syn, m_stall, m_issue;
    bit [31:0] m_view;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic eval();
        m_view = pend_m;
`ifdef ISSUE_BYPASS_EN
        if (wb_is_writereg && wb_is_regdest != 0) m_view[wb_is_regdest] = 1'b0;
`endif
        m_raw   = (id_is_numop >= 1 && id_is_addra != 0 && m_view[id_is_addra]) ||
                  (id_is_numop >= 2 && id_is_addrb != 0 && m_view[id_is_addrb]);
        m_waw   = id_is_writereg && id_is_regdest != 0 && m_view[id_is_regdest];
        m_str   = (id_is_readmem || id_is_writemem) && memcnt_m != 0;
        m_syn   = id_is_sync && (m_view != 0 || memcnt_m != 0);
        m_stall = reset && id_is_valid && (m_raw || m_waw || m_str || m_syn);
        m_issue = id_is_valid && !m_stall;
    endtask

    // One clock: check all outputs against the model, then advance the model.
    task automatic tick();
        int        nstate;
        bit [31:0] npend;
        int        nmem;
        #1;
        eval();
        chk("if_stall", {31'd0, is_if_stall}, {31'd0, m_stall});
        chk("ex_issue", {31'd0, is_ex_issue}, {31'd0, m_issue});
        chk("pending", is_pending, pend_m);
        chk("state", {30'd0, is_state}, state_m);
        chk("stallcnt", {16'd0, is_stallcnt}, stallcnt_m);
        nstate = state_m;
        if (state_m == RUN) begin
            if (m_stall) nstate = m_syn ? DRAIN : HOLD;
        end else if (state_m == HOLD) begin
            if (!id_is_valid || !m_stall) nstate = RUN;
            else if (m_syn && !m_raw && !m_waw && !m_str) nstate = DRAIN;
        end else begin
            if (!id_is_valid || (m_view == 0 && memcnt_m == 0)) nstate = RUN;
        end
        npend = pend_m;
        if (wb_is_writereg && wb_is_regdest != 0) npend[wb_is_regdest] = 1'b0;
        if (m_issue && id_is_writereg && id_is_regdest != 0) npend[id_is_regdest] = 1'b1;
        npend[0] = 1'b0;
        if (m_issue && (id_is_readmem || id_is_writemem)) nmem = LAT;
        else nmem = (memcnt_m > 0) ? memcnt_m - 1 : 0;
        @(posedge clock);
        pend_m   = npend;
        memcnt_m = nmem;
        state_m  = nstate;
        if (m_stall && stallcnt_m < 65535) stallcnt_m++;
        @(negedge clock);
    endtask

    task automatic idle();
        id_is_valid = 0; id_is_addra = 0; id_is_addrb = 0; id_is_numop = 0;
        id_is_regdest = 0; id_is_writereg = 0; id_is_readmem = 0; id_is_writemem = 0;
        id_is_sync = 0; wb_is_regdest = 0; wb_is_writereg = 0;
    endtask

    // Pulse reset for one cycle, checking the asynchronous clear and pass-through issue.
    task automatic do_reset();
        reset = 0;
        pend_m = 0; memcnt_m = 0; stallcnt_m = 0; state_m = RUN;
        #1;
        chk("rst_pending", is_pending, 32'd0);
        chk("rst_state", {30'd0, is_state}, RUN);
        chk("rst_stallcnt", {16'd0, is_stallcnt}, 32'd0);
        chk("rst_if_stall", {31'd0, is_if_stall}, 32'd0);
        chk("rst_ex_issue", {31'd0, is_ex_issue}, {31'd0, id_is_valid});
        @(posedge clock);
        @(negedge clock);
        reset = 1;
    endtask

    task automatic wr(input logic [4:0] rd);
        idle(); id_is_valid = 1; id_is_writereg = 1; id_is_regdest = rd;
        tick();
    endtask

    initial begin
        int stall_cycles;
        bit exp_b;
        idle();
        reset = 0;
        @(negedge clock);
        id_is_valid = 1;
        do_reset();
        idle();

        // RAW on r5, released by writeback
        wr(5'd5);
        idle(); id_is_valid = 1; id_is_numop = 1; id_is_addra = 5'd5;
        #1 chk("raw_stall", {31'd0, is_if_stall}, 32'd1);
        tick();
        chk("raw_hold", {30'd0, is_state}, HOLD);
        wb_is_writereg = 1; wb_is_regdest = 5'd5;
`ifdef ISSUE_BYPASS_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        #1 chk("raw_wb_stall", {31'd0, is_if_stall}, {31'd0, exp_b});
        tick();
        wb_is_writereg = 0;
        #1 chk("raw_after_wb", {31'd0, is_if_stall}, 32'd0);
        tick();

        // Load then store: three structural stall cycles
        do_reset();
        idle(); id_is_valid = 1; id_is_readmem = 1;
        tick();
        idle(); id_is_valid = 1; id_is_writemem = 1;
        stall_cycles = 0;
        for (int i = 0; i < 6 && is_if_stall !== 1'b0 || i == 0; i++) begin
            #1;
            if (is_if_stall === 1'b1) stall_cycles++;
            tick();
        end
        chk("mem_stall_cycles", stall_cycles, 32'd3);
        chk("mem_stallcnt", {16'd0, is_stallcnt}, 32'd3);

        // Sync drains outstanding r3
        do_reset();
        wr(5'd3);
        idle(); id_is_valid = 1; id_is_sync = 1;
        tick();
        chk("sync_drain", {30'd0, is_state}, DRAIN);
        tick();
        wb_is_writereg = 1; wb_is_regdest = 5'd3;
`ifdef ISSUE_BYPASS_EN
        #1 chk("sync_issue_wb", {31'd0, is_ex_issue}, 32'd1);
        tick();
        idle();
        tick();
`else
        #1 chk("sync_issue_wb", {31'd0, is_ex_issue}, 32'd0);
        tick();
        wb_is_writereg = 0;
        #1 chk("sync_issue", {31'd0, is_ex_issue}, 32'd1);
        tick();
`endif
        chk("sync_run", {30'd0, is_state}, RUN);

        // Same-edge set and clear of r7 leaves it set
        do_reset();
        idle(); id_is_valid = 1; id_is_writereg = 1; id_is_regdest = 5'd7;
        wb_is_writereg = 1; wb_is_regdest = 5'd7;
        tick();
        chk("set_wins", is_pending, 32'h0000_0080);

        // r0 is never tracked
        do_reset();
        wr(5'd0);
        chk("r0_pend", is_pending, 32'd0);
        idle(); id_is_valid = 1; id_is_numop = 1; id_is_addra = 5'd0;
        #1 chk("r0_stall", {31'd0, is_if_stall}, 32'd0);
        tick();

        // Reset mid-DRAIN discards r4/r8
        do_reset();
        wr(5'd4);
        wr(5'd8);
        idle(); id_is_valid = 1; id_is_sync = 1;
        tick();
        chk("drain_pend", is_pending, 32'h0000_0110);
        chk("drain_state", {30'd0, is_state}, DRAIN);
        do_reset();

        // Randomized traffic; decode held while the model says stalled
        idle();
        m_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                do_reset();
                m_stall = 0;
            end
            if (!m_stall) begin
                id_is_valid    = ($urandom_range(0, 3) != 0);
                id_is_addra    = 5'($urandom_range(0, 7));
                id_is_addrb    = 5'($urandom_range(0, 7));
                id_is_numop    = 2'($urandom_range(0, 3));
                id_is_regdest  = 5'($urandom_range(0, 7));
                id_is_writereg = 1'($urandom_range(0, 1));
                id_is_readmem  = ($urandom_range(0, 5) == 0);
                id_is_writemem = ($urandom_range(0, 5) == 0);
                id_is_sync     = ($urandom_range(0, 9) == 0);
            end
            wb_is_writereg = 1'($urandom_range(0, 1));
            wb_is_regdest  = 5'($urandom_range(0, 7));
            if (pend_m != 0 && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 16; k++) begin
                    int r;
                    r = $urandom_range(1, 31);
                    if (pend_m[r]) begin
                        wb_is_regdest = 5'(r);
                        break;
                    end
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
